vx_onehot_stream_demux: RTL and testbench

- Routes one valid/ready input stream to exactly one of N output streams, chosen by a one-hot select that travels with each transaction.
- It is the inverse of the one-hot mux: the mux gathers N sources into one, this block scatters one source to N sinks.
- Sits between dispatch/arbitration logic and per-lane or per-bank consumers.
- Optional per-output 2-entry buffering breaks the combinational ready path while keeping full throughput.

---
 rtl/vx_onehot_stream_demux_pkg.sv | 7 +
 rtl/vx_onehot_stream_demux_skid_slot.sv | 112 +++++++++++
 rtl/vx_onehot_stream_demux.sv | 68 ++++++
 tb/tb_vx_onehot_stream_demux.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vx_onehot_stream_demux_pkg.sv
// Shared constants for the one-hot stream demultiplexer.
package vx_onehot_stream_demux_pkg;

    localparam int unsigned OUT_BUF_NONE = 0;
    localparam int unsigned OUT_BUF_SKID = 1;

endpackage

// File: rtl/vx_onehot_stream_demux_skid_slot.sv
// Two-entry output buffer: head feeds the consumer, skid absorbs one extra beat
// so the upstream ready is a pure decode of the slot state.
module vx_onehot_stream_demux_skid_slot
    import vx_onehot_stream_demux_pkg::*;
#(
    parameter int unsigned DATAW = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [DATAW-1:0] push_data,
    output logic             push_ready,
    output logic             pop_valid,
    output logic [DATAW-1:0] pop_data,
    input  logic             pop_ready
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [DATAW-1:0] head;
    logic [DATAW-1:0] skid;
    logic             pop;
    logic             load_head_in;
    logic             load_head_skid;
    logic             load_skid;

    assign pop      = pop_valid & pop_ready;
    assign pop_data = head;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Next state and payload load enables
    always_comb begin
        state_next     = state;
        load_head_in   = 1'b0;
        load_head_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (push) begin
                    state_next   = ST_ONE;
                    load_head_in = 1'b1;
                end
            end
            ST_ONE: begin
                if (push && pop) begin
                    load_head_in = 1'b1;
                end else if (push) begin
                    state_next = ST_TWO;
                    load_skid  = 1'b1;
                end else if (pop) begin
                    state_next = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (pop) begin
                    state_next     = ST_ONE;
                    load_head_skid = 1'b1;
                end
            end
            default: begin
                state_next = ST_EMPTY;
            end
        endcase
    end

    // Outputs decode the state register only
    always_comb begin
        pop_valid  = 1'b0;
        push_ready = 1'b0;
        case (state)
            ST_EMPTY: begin
                push_ready = 1'b1;
            end
            ST_ONE: begin
                pop_valid  = 1'b1;
                push_ready = 1'b1;
            end
            ST_TWO: begin
                pop_valid = 1'b1;
            end
            default: begin
                pop_valid  = 1'b0;
                push_ready = 1'b0;
            end
        endcase
    end

    // Payload registers are intentionally not reset
    always_ff @(posedge clk) begin
        if (load_head_in) begin
            head <= push_data;
        end else if (load_head_skid) begin
            head <= skid;
        end
        if (load_skid) begin
            skid <= push_data;
        end
    end

endmodule

// File: rtl/vx_onehot_stream_demux.sv
// Scatters one valid/ready stream to one of N sinks chosen by a one-hot select,
// either combinationally or through a per-output two-entry buffer.
module vx_onehot_stream_demux
    import vx_onehot_stream_demux_pkg::*;
#(
    parameter int unsigned DATAW   = 1,
    parameter int unsigned N       = 1,
    parameter int unsigned OUT_BUF = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               valid_in,
    input  logic [DATAW-1:0]   data_in,
    input  logic [N-1:0]       sel_in,
    output logic               ready_in,
    output logic [N-1:0]       valid_out,
    output logic [N*DATAW-1:0] data_out,
    input  logic [N-1:0]       ready_out
);

    logic [N-1:0] sel_eff;
    logic         sel_none;
    logic         unused_sel;

    // A single output ignores the select entirely
    if (N == 1) begin : g_single
        assign sel_eff    = '1;
        assign sel_none   = 1'b0;
        assign unused_sel = ^sel_in;
    end else begin : g_multi
        assign sel_eff    = sel_in;
        assign sel_none   = (sel_in == '0);
        assign unused_sel = 1'b0;
    end

    if (OUT_BUF == OUT_BUF_NONE) begin : g_comb
        logic unused_clk;
        assign unused_clk = clk ^ reset;
        assign valid_out  = {N{valid_in}} & sel_eff;
        assign data_out   = {N{data_in}};
        assign ready_in   = sel_none | (|(sel_eff & ready_out));
    end else begin : g_buf
        logic [N-1:0] slot_ready;
        logic [N-1:0] push;

        assign push     = {N{valid_in}} & sel_eff & slot_ready;
        assign ready_in = sel_none | (|(sel_eff & slot_ready));

        for (genvar i = 0; i < int'(N); i++) begin : g_slot
            vx_onehot_stream_demux_skid_slot #(
                .DATAW (DATAW)
            ) u_slot (
                .clk        (clk),
                .reset      (reset),
                .push       (push[i]),
                .push_data  (data_in),
                .push_ready (slot_ready[i]),
                .pop_valid  (valid_out[i]),
                .pop_data   (data_out[i*DATAW +: DATAW]),
                .pop_ready  (ready_out[i])
            );
        end
    end

    a_sel_onehot: assert property (@(posedge clk) disable iff (reset)
        valid_in |-> $onehot0(sel_in));

endmodule

// File: tb/tb_vx_onehot_stream_demux.sv
// Bench for the one-hot stream demux: combinational and buffered instances, N=4, DATAW=8.
module tb_vx_onehot_stream_demux;

    logic        clk;
    logic        reset;
    logic        valid_in;
    logic [7:0]  data_in;
    logic [3:0]  sel_in;
    logic [3:0]  ready_out;

    logic        c_ready_in;
    logic [3:0]  c_valid_out;
    logic [31:0] c_data_out;
    logic        b_ready_in;
    logic [3:0]  b_valid_out;
    logic [31:0] b_data_out;

    int vectors;
    int fails;

    // Scoreboard of beats expected per buffered output, in acceptance order
    logic [7:0] exp_q [4][$];

    vx_onehot_stream_demux #(.DATAW(8), .N(4), .OUT_BUF(0)) u_comb (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .sel_in    (sel_in),
        .ready_in  (c_ready_in),
        .valid_out (c_valid_out),
        .data_out  (c_data_out),
        .ready_out (ready_out)
    );

    vx_onehot_stream_demux #(.DATAW(8), .N(4), .OUT_BUF(1)) u_buf (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .sel_in    (sel_in),
        .ready_in  (b_ready_in),
        .valid_out (b_valid_out),
        .data_out  (b_data_out),
        .ready_out (ready_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] exp_valid_b();
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = (exp_q[i].size() != 0);
        return v;
    endfunction

    function automatic logic exp_ready_b(input logic [3:0] s);
        logic [3:0] sr;
        for (int i = 0; i < 4; i++) sr[i] = (exp_q[i].size() < 2);
        return (s == 4'b0000) | (|(s & sr));
    endfunction

    task automatic drive(input logic v, input logic [3:0] s, input logic [7:0] d, input logic [3:0] r);
        valid_in  = v;
        sel_in    = s;
        data_in   = d;
        ready_out = r;
    endtask

    // Advance one clock and update the scoreboard the way the buffered design should
    task automatic tick();
        int sz[4];
        @(posedge clk);
        for (int i = 0; i < 4; i++) sz[i] = exp_q[i].size();
        if (reset) begin
            for (int i = 0; i < 4; i++) exp_q[i].delete();
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (sz[i] != 0 && ready_out[i]) void'(exp_q[i].pop_front());
                if (valid_in && sel_in[i] && sz[i] < 2) exp_q[i].push_back(data_in);
            end
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b0, 4'b1111, 8'h00, 4'b0000);
        tick();
        tick();
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if (b_valid_out !== 4'b0000) begin
            fails++;
            $display("FAIL reset valid_out got=%b exp=0000", b_valid_out);
        end
        vectors++;
        if (b_ready_in !== 1'b1) begin
            fails++;
            $display("FAIL reset ready_in got=%b exp=1", b_ready_in);
        end
        tick();
    endtask

    task automatic test_comb();
        drive(1'b1, 4'b0100, 8'hA5, 4'b0100);
        #1;
        vectors++;
        if (c_valid_out !== 4'b0100) begin
            fails++;
            $display("FAIL comb valid_out got=%b exp=0100", c_valid_out);
        end
        vectors++;
        if (c_data_out[23:16] !== 8'hA5) begin
            fails++;
            $display("FAIL comb data_out[2] got=%h exp=a5", c_data_out[23:16]);
        end
        vectors++;
        if (c_data_out[7:0] !== 8'hA5) begin
            fails++;
            $display("FAIL comb data_out[0] got=%h exp=a5", c_data_out[7:0]);
        end
        vectors++;
        if (c_ready_in !== 1'b1) begin
            fails++;
            $display("FAIL comb ready_in got=%b exp=1", c_ready_in);
        end
        ready_out = 4'b1011;
        #1;
        vectors++;
        if (c_ready_in !== 1'b0) begin
            fails++;
            $display("FAIL comb stalled ready_in got=%b exp=0", c_ready_in);
        end
        vectors++;
        if (c_valid_out !== 4'b0100) begin
            fails++;
            $display("FAIL comb stalled valid_out got=%b exp=0100", c_valid_out);
        end
        sel_in = 4'b0000;
        #1;
        vectors++;
        if (c_ready_in !== 1'b1 || c_valid_out !== 4'b0000) begin
            fails++;
            $display("FAIL comb drop ready_in=%b valid_out=%b exp 1/0000", c_ready_in, c_valid_out);
        end
        drive(1'b0, 4'b0000, 8'h00, 4'b0000);
        tick();
    endtask

    task automatic test_stream();
        logic [3:0] e_v;
        logic       e_r;
        for (int k = 0; k < 10; k++) begin
            if (k < 8) drive(1'b1, 4'b0001, 8'(k), 4'b1111);
            else       drive(1'b0, 4'b0000, 8'h00, 4'b1111);
            @(negedge clk);
            e_v = exp_valid_b();
            e_r = exp_ready_b(sel_in);
            vectors++;
            if (b_valid_out !== e_v) begin
                fails++;
                $display("FAIL stream[%0d] valid_out got=%b exp=%b", k, b_valid_out, e_v);
            end
            vectors++;
            if (b_ready_in !== e_r) begin
                fails++;
                $display("FAIL stream[%0d] ready_in got=%b exp=%b", k, b_ready_in, e_r);
            end
            for (int i = 0; i < 4; i++) begin
                if (e_v[i]) begin
                    vectors++;
                    if (b_data_out[i*8 +: 8] !== exp_q[i][0]) begin
                        fails++;
                        $display("FAIL stream[%0d] data_out[%0d] got=%h exp=%h", k, i, b_data_out[i*8 +: 8], exp_q[i][0]);
                    end
                end
            end
            if (k >= 1 && k <= 8) begin
                vectors++;
                if (b_valid_out[0] !== 1'b1 || b_data_out[7:0] !== 8'(k - 1)) begin
                    fails++;
                    $display("FAIL stream[%0d] lane0 got v=%b d=%h exp v=1 d=%h", k, b_valid_out[0], b_data_out[7:0], 8'(k - 1));
                end
            end
            tick();
        end
    endtask

    task automatic test_stall();
        logic [16:0] vec [7];
        logic [3:0]  e_v;
        logic        e_r;
        vec = '{ {1'b1, 4'b0010, 8'h11, 4'b0000},
                 {1'b1, 4'b0010, 8'h22, 4'b0000},
                 {1'b1, 4'b0010, 8'h33, 4'b0000},
                 {1'b1, 4'b0010, 8'h33, 4'b0010},
                 {1'b1, 4'b0010, 8'h33, 4'b0010},
                 {1'b0, 4'b0000, 8'h00, 4'b0010},
                 {1'b0, 4'b0000, 8'h00, 4'b0010} };
        for (int k = 0; k < 7; k++) begin
            drive(vec[k][16], vec[k][15:12], vec[k][11:4], vec[k][3:0]);
            @(negedge clk);
            e_v = exp_valid_b();
            e_r = exp_ready_b(sel_in);
            vectors++;
            if (b_valid_out !== e_v) begin
                fails++;
                $display("FAIL stall[%0d] valid_out got=%b exp=%b", k, b_valid_out, e_v);
            end
            vectors++;
            if (b_ready_in !== e_r) begin
                fails++;
                $display("FAIL stall[%0d] ready_in got=%b exp=%b", k, b_ready_in, e_r);
            end
            for (int i = 0; i < 4; i++) begin
                if (e_v[i]) begin
                    vectors++;
                    if (b_data_out[i*8 +: 8] !== exp_q[i][0]) begin
                        fails++;
                        $display("FAIL stall[%0d] data_out[%0d] got=%h exp=%h", k, i, b_data_out[i*8 +: 8], exp_q[i][0]);
                    end
                end
            end
            if (k == 2) begin
                vectors++;
                if (b_ready_in !== 1'b0) begin
                    fails++;
                    $display("FAIL stall full ready_in got=%b exp=0", b_ready_in);
                end
            end
            tick();
        end
    endtask

    task automatic test_no_hol();
        logic [16:0] vec [7];
        logic [3:0]  e_v;
        logic        e_r;
        vec = '{ {1'b1, 4'b0001, 8'hA1, 4'b0000},
                 {1'b1, 4'b0001, 8'hA2, 4'b0000},
                 {1'b1, 4'b1000, 8'h7E, 4'b0000},
                 {1'b0, 4'b0000, 8'h00, 4'b0000},
                 {1'b0, 4'b0000, 8'h00, 4'b1111},
                 {1'b0, 4'b0000, 8'h00, 4'b1111},
                 {1'b0, 4'b0000, 8'h00, 4'b1111} };
        for (int k = 0; k < 7; k++) begin
            drive(vec[k][16], vec[k][15:12], vec[k][11:4], vec[k][3:0]);
            @(negedge clk);
            e_v = exp_valid_b();
            e_r = exp_ready_b(sel_in);
            vectors++;
            if (b_valid_out !== e_v) begin
                fails++;
                $display("FAIL nohol[%0d] valid_out got=%b exp=%b", k, b_valid_out, e_v);
            end
            vectors++;
            if (b_ready_in !== e_r) begin
                fails++;
                $display("FAIL nohol[%0d] ready_in got=%b exp=%b", k, b_ready_in, e_r);
            end
            for (int i = 0; i < 4; i++) begin
                if (e_v[i]) begin
                    vectors++;
                    if (b_data_out[i*8 +: 8] !== exp_q[i][0]) begin
                        fails++;
                        $display("FAIL nohol[%0d] data_out[%0d] got=%h exp=%h", k, i, b_data_out[i*8 +: 8], exp_q[i][0]);
                    end
                end
            end
            if (k == 2) begin
                vectors++;
                if (b_ready_in !== 1'b1) begin
                    fails++;
                    $display("FAIL nohol bypass ready_in got=%b exp=1", b_ready_in);
                end
            end
            if (k == 3) begin
                vectors++;
                if (b_valid_out !== 4'b1001 || b_data_out[31:24] !== 8'h7E || b_data_out[7:0] !== 8'hA1) begin
                    fails++;
                    $display("FAIL nohol lanes got v=%b d3=%h d0=%h exp v=1001 d3=7e d0=a1", b_valid_out, b_data_out[31:24], b_data_out[7:0]);
                end
            end
            tick();
        end
    endtask

    task automatic test_drop();
        drive(1'b1, 4'b0000, 8'hFF, 4'b1111);
        @(negedge clk);
        vectors++;
        if (b_ready_in !== 1'b1) begin
            fails++;
            $display("FAIL drop ready_in got=%b exp=1", b_ready_in);
        end
        tick();
        drive(1'b0, 4'b0000, 8'h00, 4'b1111);
        @(negedge clk);
        vectors++;
        if (b_valid_out !== 4'b0000) begin
            fails++;
            $display("FAIL drop valid_out got=%b exp=0000", b_valid_out);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 4'b0001, 8'h10, 4'b0000);
        tick();
        drive(1'b1, 4'b0100, 8'h20, 4'b0000);
        tick();
        drive(1'b0, 4'b0000, 8'h00, 4'b0000);
        @(negedge clk);
        vectors++;
        if (b_valid_out !== 4'b0101 || b_valid_out !== exp_valid_b()) begin
            fails++;
            $display("FAIL rstmid held valid_out got=%b exp=0101", b_valid_out);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(1'b1, 4'b0100, 8'h5A, 4'b0100);
        @(negedge clk);
        vectors++;
        if (b_valid_out !== 4'b0000) begin
            fails++;
            $display("FAIL rstmid cleared valid_out got=%b exp=0000", b_valid_out);
        end
        vectors++;
        if (b_ready_in !== 1'b1) begin
            fails++;
            $display("FAIL rstmid ready_in got=%b exp=1", b_ready_in);
        end
        tick();
        drive(1'b0, 4'b0000, 8'h00, 4'b0100);
        @(negedge clk);
        vectors++;
        if (b_valid_out !== 4'b0100 || b_data_out[23:16] !== exp_q[2][0] || b_data_out[23:16] !== 8'h5A) begin
            fails++;
            $display("FAIL rstmid new beat got v=%b d2=%h exp v=0100 d2=5a", b_valid_out, b_data_out[23:16]);
        end
        tick();
        @(negedge clk);
        vectors++;
        if (b_valid_out !== 4'b0000) begin
            fails++;
            $display("FAIL rstmid drained valid_out got=%b exp=0000", b_valid_out);
        end
        tick();
    endtask

    initial begin
        vectors = 0;
        fails   = 0;
        reset   = 1'b1;
        drive(1'b0, 4'b0000, 8'h00, 4'b0000);
        test_reset();
        test_comb();
        test_stream();
        test_stall();
        test_no_hol();
        test_drop();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
